// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - edge-detecting, masked, fixed-priority interrupt controller with ISR tracking
module irq_ctrl #(
   parameter int N_SRC = 4,
   parameter int ID_W  = $clog2(N_SRC)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] src_irq,
   input  logic             irq_entry,
   input  logic             irq_resume,
   output logic             irq,
   output logic             irq_active,
   output logic [ID_W-1:0]  irq_id,
   input  logic             reg_we,
   input  logic [1:0]       reg_addr,
   input  logic [31:0]      reg_wdata,
   output logic [31:0]      reg_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ    = 2'd1,
      ST_ACTIVE = 2'd2
   } state_t;

   localparam logic [1:0] A_CTRL    = 2'd0;
   localparam logic [1:0] A_MASK    = 2'd1;
   localparam logic [1:0] A_PENDING = 2'd2;
   localparam logic [1:0] A_CAUSE   = 2'd3;

   state_t             state_q, state_d;
   logic [N_SRC-1:0]   src_q;
   logic [N_SRC-1:0]   pending_q, pending_d;
   logic [N_SRC-1:0]   mask_q, mask_d;
   logic               gie_q, gie_d;
   logic [ID_W-1:0]    irq_id_q, irq_id_d;

   logic [N_SRC-1:0]   rise;
   logic [N_SRC-1:0]   elig;
   logic               any_elig;
   logic [ID_W-1:0]    winner;
   logic               take;
   logic [N_SRC-1:0]   entry_clr;
   logic [N_SRC-1:0]   w1c_clr;

   // upper write-data bits have no register behind them
   logic               unused_wdata;
   assign unused_wdata = ^reg_wdata[31:N_SRC];

   assign rise     = src_irq & ~src_q;
   assign elig     = pending_q & mask_q & {N_SRC{gie_q}};
   assign any_elig = |elig;

   // lowest eligible index wins: scan from the top so the lowest set bit is written last
   always_comb begin
      winner = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (elig[i]) begin
            winner = ID_W'(i);
         end
      end
   end

   // request/ISR sequencing; an emptied eligible set in REQ withdraws the request before entry can latch
   always_comb begin
      state_d  = state_q;
      irq_id_d = irq_id_q;
      take     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (any_elig) begin
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (!any_elig) begin
               state_d = ST_IDLE;
            end else if (irq_entry) begin
               take     = 1'b1;
               irq_id_d = winner;
               state_d  = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            if (irq_resume) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // pending: both clears apply, and a fresh rise on the same bit overrides either clear
   always_comb begin
      entry_clr = take ? (N_SRC'(1) << winner) : '0;
      w1c_clr   = (reg_we && (reg_addr == A_PENDING)) ? reg_wdata[N_SRC-1:0] : '0;
      pending_d = (pending_q & ~w1c_clr & ~entry_clr) | rise;
   end

   // software-written control and mask registers
   always_comb begin
      gie_d  = gie_q;
      mask_d = mask_q;
      if (reg_we && (reg_addr == A_CTRL)) begin
         gie_d = reg_wdata[0];
      end
      if (reg_we && (reg_addr == A_MASK)) begin
         mask_d = reg_wdata[N_SRC-1:0];
      end
   end

   // state register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         src_q     <= '0;
         pending_q <= '0;
         mask_q    <= '0;
         gie_q     <= 1'b0;
         irq_id_q  <= '0;
      end else begin
         state_q   <= state_d;
         src_q     <= src_irq;
         pending_q <= pending_d;
         mask_q    <= mask_d;
         gie_q     <= gie_d;
         irq_id_q  <= irq_id_d;
      end
   end

   // both outputs are pure decodes of the state flop, so they behave as registered signals
   assign irq        = (state_q == ST_REQ);
   assign irq_active = (state_q == ST_ACTIVE);
   assign irq_id     = irq_id_q;

   // combinational register read-back
   always_comb begin
      reg_rdata = '0;
      case (reg_addr)
         A_CTRL:    reg_rdata = 32'(gie_q);
         A_MASK:    reg_rdata = 32'(mask_q);
         A_PENDING: reg_rdata = 32'(pending_q);
         A_CAUSE:   reg_rdata = (32'(irq_active) << 8) | 32'(irq_id_q);
         default:   reg_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - scoreboard bench for irq_ctrl with a transaction-level reference model
module tb_irq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  src_irq;
   logic        irq_entry;
   logic        irq_resume;
   logic        irq;
   logic        irq_active;
   logic [1:0]  irq_id;
   logic        reg_we;
   logic [1:0]  reg_addr;
   logic [31:0] reg_wdata;
   logic [31:0] reg_rdata;

   irq_ctrl #(.N_SRC(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .src_irq    (src_irq),
      .irq_entry  (irq_entry),
      .irq_resume (irq_resume),
      .irq        (irq),
      .irq_active (irq_active),
      .irq_id     (irq_id),
      .reg_we     (reg_we),
      .reg_addr   (reg_addr),
      .reg_wdata  (reg_wdata),
      .reg_rdata  (reg_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        irq;
      logic        act;
      logic [1:0]  id;
      logic [31:0] rd;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // reference model: controller state as seen by software
   logic [3:0] m_prev = '0;
   logic [3:0] m_pend = '0;
   logic [3:0] m_mask = '0;
   bit         m_gie  = 0;
   bit         m_req  = 0;
   bit         m_act  = 0;
   logic [1:0] m_id   = '0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [1:0] a);
      case (a)
         2'd0:    return {31'd0, m_gie};
         2'd1:    return {28'd0, m_mask};
         2'd2:    return {28'd0, m_pend};
         default: return ({31'd0, m_act} * 256) + {30'd0, m_id};
      endcase
   endfunction

   // what a control unit would drive: entry whenever a request is up and no ISR runs
   function automatic bit cu_entry();
      return m_req && !m_act;
   endfunction

   // one clock: drive inputs, advance the model, queue the expected post-edge view, land on negedge
   task automatic step(input logic [3:0] s, input logic we, input logic [1:0] a, input logic [31:0] wd,
                       input logic ent, input logic res, input logic rstn);
      logic [3:0] elig;
      logic [3:0] np;
      exp_t       e;
      src_irq    = s;
      reg_we     = we;
      reg_addr   = a;
      reg_wdata  = wd;
      irq_entry  = ent;
      irq_resume = res;
      rst        = rstn;
      if (!rstn) begin
         m_prev = '0; m_pend = '0; m_mask = '0; m_gie = 0;
         m_req = 0; m_act = 0; m_id = '0;
      end else begin
         elig = m_gie ? (m_pend & m_mask) : 4'd0;
         np   = m_pend;
         if (we && a == 2'd2) np = np & ~wd[3:0];
         if (m_req) begin
            if (elig == 0) begin
               m_req = 0;
            end else if (ent) begin
               for (int i = 3; i >= 0; i--) if (elig[i]) m_id = 2'(i);
               np[m_id] = 1'b0;
               m_req = 0;
               m_act = 1;
            end
         end else if (m_act) begin
            if (res) m_act = 0;
         end else if (elig != 0) begin
            m_req = 1;
         end
         m_pend = np | (s & ~m_prev);
         m_prev = s;
         if (we && a == 2'd0) m_gie = wd[0];
         if (we && a == 2'd1) m_mask = wd[3:0];
      end
      e.irq = m_req;
      e.act = m_act;
      e.id  = m_id;
      e.rd  = m_read(a);
      sb_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic cyc(input logic [3:0] s, input logic [1:0] a);
      step(s, 1'b0, a, 32'd0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      step(4'd0, 1'b1, a, d, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic take(input logic [1:0] a);
      step(4'd0, 1'b0, a, 32'd0, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic resume(input logic [1:0] a);
      step(4'd0, 1'b0, a, 32'd0, 1'b0, 1'b1, 1'b1);
   endtask

   // monitor: the DUT presents a new output view after every edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("irq", {31'd0, irq}, {31'd0, e.irq});
            chk("irq_active", {31'd0, irq_active}, {31'd0, e.act});
            chk("irq_id", {30'd0, irq_id}, {30'd0, e.id});
            chk("reg_rdata", reg_rdata, e.rd);
         end
      end
   end

   initial begin
      int services;
      bit prev_act;
      logic [3:0]  s;
      logic        we, ent, res, rn;
      logic [1:0]  a;
      logic [31:0] wd;

      rst = 1'b0; src_irq = '0; irq_entry = 1'b0; irq_resume = 1'b0;
      reg_we = 1'b0; reg_addr = '0; reg_wdata = '0;
      @(negedge clk);

      // reset, reading every address while held
      for (int i = 0; i < 4; i++) begin
         step(4'd0, 1'b0, 2'(i), 32'd0, 1'b0, 1'b0, 1'b0);
         chk("rst_read", reg_rdata, 32'd0);
      end
      chk("rst_irq", {31'd0, irq}, 32'd0);
      chk("rst_active", {31'd0, irq_active}, 32'd0);
      chk("rst_id", {30'd0, irq_id}, 32'd0);

      // single source, full service
      wr(2'd1, 32'hF);
      wr(2'd0, 32'h1);
      cyc(4'b0100, 2'd0);
      chk("lat_irq_low", {31'd0, irq}, 32'd0);
      cyc(4'b0000, 2'd0);
      chk("lat_irq_high", {31'd0, irq}, 32'd1);
      take(2'd3);
      chk("cause_102", reg_rdata, 32'h102);
      chk("id_2", {30'd0, irq_id}, 32'd2);
      chk("irq_dropped", {31'd0, irq}, 32'd0);
      cyc(4'b0000, 2'd2);
      chk("pend_cleared", reg_rdata, 32'd0);
      resume(2'd0);
      chk("resume_idle", {31'd0, irq_active}, 32'd0);

      // two sources in one cycle: lower index first, one gap cycle between ISRs
      cyc(4'b1010, 2'd0);
      cyc(4'b0000, 2'd0);
      take(2'd0);
      chk("first_id_1", {30'd0, irq_id}, 32'd1);
      resume(2'd0);
      chk("gap_cycle", {31'd0, irq}, 32'd0);
      cyc(4'b0000, 2'd0);
      chk("reassert", {31'd0, irq}, 32'd1);
      take(2'd0);
      chk("second_id_3", {30'd0, irq_id}, 32'd3);
      resume(2'd0);

      // masked source stays pending, unmask raises, W1C in REQ withdraws
      wr(2'd1, 32'h0);
      cyc(4'b0001, 2'd0);
      cyc(4'b0000, 2'd2);
      chk("masked_no_irq", {31'd0, irq}, 32'd0);
      chk("masked_pending", reg_rdata, 32'd1);
      wr(2'd1, 32'h1);
      cyc(4'b0000, 2'd0);
      chk("unmask_irq", {31'd0, irq}, 32'd1);
      wr(2'd2, 32'h1);
      cyc(4'b0000, 2'd0);
      chk("w1c_withdraw", {31'd0, irq}, 32'd0);

      // rise during ACTIVE accumulates, then reset mid-ISR
      wr(2'd1, 32'hF);
      cyc(4'b0100, 2'd0);
      cyc(4'b0000, 2'd0);
      take(2'd0);
      cyc(4'b0001, 2'd0);
      cyc(4'b0000, 2'd2);
      chk("active_no_irq", {31'd0, irq}, 32'd0);
      chk("active_pend0", reg_rdata, 32'd1);
      resume(2'd0);
      chk("post_resume_gap", {31'd0, irq}, 32'd0);
      cyc(4'b0000, 2'd0);
      chk("post_resume_irq", {31'd0, irq}, 32'd1);
      take(2'd0);
      step(4'd0, 1'b0, 2'd1, 32'd0, 1'b0, 1'b0, 1'b0);
      chk("rst_mid_isr", {31'd0, irq_active}, 32'd0);
      chk("rst_mask", reg_rdata, 32'd0);

      // rise beats same-cycle W1C; a held source is serviced only once
      wr(2'd1, 32'hF);
      wr(2'd0, 32'h1);
      step(4'b0010, 1'b1, 2'd2, 32'h2, 1'b0, 1'b0, 1'b1);
      chk("set_beats_w1c", reg_rdata, 32'h2);
      services = 0;
      prev_act = 0;
      for (int i = 0; i < 12; i++) begin
         step((i < 10) ? 4'b0010 : 4'b0000, 1'b0, 2'd0, 32'd0, cu_entry(), m_act, 1'b1);
         if (irq_active && !prev_act) services++;
         prev_act = irq_active;
      end
      chk("held_once", services, 32'd1);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         s   = ($urandom_range(0, 2) == 0) ? 4'($urandom()) : m_prev & 4'($urandom());
         we  = ($urandom_range(0, 7) == 0);
         a   = 2'($urandom());
         wd  = $urandom();
         if (we && a == 2'd0 && $urandom_range(0, 3) != 0) wd[0] = 1'b1;
         ent = ($urandom_range(0, 3) != 0) ? cu_entry() : ($urandom_range(0, 15) == 0);
         res = m_act ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
         rn  = ($urandom_range(0, 299) != 0);
         step(s, we, a, wd, ent, res, rn);
      end

      @(posedge clk);
      #2;
      chk("sb_drain", sb_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
